// File: rtl/shift_ctrl_pkg.sv
// Shared types and helpers for the mux_dff parallel-to-serial sequencer.
package shift_ctrl_pkg;

    typedef enum logic {IDLE, SHIFT} shift_state_t;

    // Bits needed to hold a count of 0..width inclusive.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mux_dff.sv
// Single chain cell: a flop whose D input selects r_in (l=1) or q_in (l=0).
module mux_dff (
    input  logic clk,
    input  logic l,
    input  logic r_in,
    input  logic q_in,
    output logic q
);

    always_ff @(posedge clk) begin
        q <= l ? r_in : q_in;
    end

endmodule

// File: rtl/mux_dff_shift_ctrl.sv
// Loads a parallel word into a chain of mux_dff cells and shifts it out MSB-first
// over a valid/ready serial handshake, with back-to-back reload on the final bit.
module mux_dff_shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter logic        FILL_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_data,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned CW = cnt_w(WIDTH);

    shift_state_t  state;
    logic [CW-1:0] count;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r_in;
    logic [WIDTH-1:0] q_in;
    logic             l;
    logic             accept;
    logic             shift_en;

    assign ser_valid = (state == SHIFT);
    assign busy      = (state == SHIFT);
    assign ser_last  = (state == SHIFT) && (count == CW'(1));
    assign ser_data  = q[WIDTH-1];

    // Only the final bit lets ser_ready reach in_ready combinationally.
    assign in_ready  = (state == IDLE) || (ser_last && ser_ready);
    assign accept    = in_ready && in_valid;
    assign shift_en  = (state == SHIFT) && ser_ready && !accept;

    always_comb begin
        l    = 1'b1;
        r_in = q;
        q_in = {q[WIDTH-2:0], FILL_BIT};
        if (reset) begin
            r_in = '0;
        end else if (accept) begin
            r_in = in_data;
        end else if (shift_en) begin
            l = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= SHIFT;
                        count <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        count <= CW'(WIDTH);
                    end else if (ser_ready) begin
                        count <= count - CW'(1);
                        if (ser_last) state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_chain
        mux_dff u_cell (
            .clk  (clk),
            .l    (l),
            .r_in (r_in[i]),
            .q_in (q_in[i]),
            .q    (q[i])
        );
    end

endmodule

// File: tb/tb_mux_dff_shift_ctrl.sv
// Randomized and directed checks of mux_dff_shift_ctrl against a word-level model,
// run on an 8-bit/fill-0 instance and a 5-bit/fill-1 instance sharing stimulus.
module tb_mux_dff_shift_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       ser_ready;

    logic       rdy0, val0, dat0, lst0, bsy0;
    logic       rdy1, val1, dat1, lst1, bsy1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_dff_shift_ctrl #(.WIDTH(8), .FILL_BIT(1'b0)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (rdy0),
        .in_data   (in_data),
        .ser_valid (val0),
        .ser_ready (ser_ready),
        .ser_data  (dat0),
        .ser_last  (lst0),
        .busy      (bsy0)
    );

    mux_dff_shift_ctrl #(.WIDTH(5), .FILL_BIT(1'b1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (rdy1),
        .in_data   (in_data[4:0]),
        .ser_valid (val1),
        .ser_ready (ser_ready),
        .ser_data  (dat1),
        .ser_last  (lst1),
        .busy      (bsy1)
    );

    // Word-level model: the resident word and how many of its bits remain.
    typedef struct {
        bit          active;
        logic [31:0] word;
        int          left;
        bit          idle_val;
    } mdl_t;

    mdl_t m[2];
    int   mw[2]   = '{8, 5};
    bit   mfill[2] = '{1'b0, 1'b1};
    bit   model_ok = 1'b0;

    // Last observed outputs of the 8-bit instance, for the directed sequence checks.
    logic obs_val, obs_dat, obs_lst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cmp_inst(input int i, input logic rdy, input logic val, input logic dat,
                            input logic lst, input logic bsy);
        logic e_last, e_rdy, e_dat;
        e_last = m[i].active && (m[i].left == 1);
        e_rdy  = !m[i].active || (e_last && ser_ready);
        e_dat  = m[i].active ? m[i].word[m[i].left-1] : m[i].idle_val;
        check($sformatf("u%0d.in_ready", i), 32'(rdy), 32'(e_rdy));
        check($sformatf("u%0d.ser_valid", i), 32'(val), 32'(m[i].active));
        check($sformatf("u%0d.busy", i), 32'(bsy), 32'(m[i].active));
        check($sformatf("u%0d.ser_last", i), 32'(lst), 32'(e_last));
        check($sformatf("u%0d.ser_data", i), 32'(dat), 32'(e_dat));
    endtask

    task automatic step_model(input int i);
        logic [31:0] d;
        d = 32'(in_data) & ((32'd1 << mw[i]) - 32'd1);
        if (reset) begin
            m[i].active   = 1'b0;
            m[i].left     = 0;
            m[i].idle_val = 1'b0;
        end else if (!m[i].active) begin
            if (in_valid) begin
                m[i].active = 1'b1;
                m[i].word   = d;
                m[i].left   = mw[i];
            end
        end else if (ser_ready) begin
            if (m[i].left == 1) begin
                if (in_valid) begin
                    m[i].word = d;
                    m[i].left = mw[i];
                end else begin
                    m[i].active   = 1'b0;
                    m[i].left     = 0;
                    m[i].idle_val = mfill[i];
                end
            end else begin
                m[i].left--;
            end
        end
    endtask

    // One clock: drive at negedge, compare just after, advance model for the coming posedge.
    task automatic cycle(input logic rst, input logic iv, input logic [7:0] data, input logic sr);
        @(negedge clk);
        reset     = rst;
        in_valid  = iv;
        in_data   = data;
        ser_ready = sr;
        #1;
        if (model_ok) begin
            cmp_inst(0, rdy0, val0, dat0, lst0, bsy0);
            cmp_inst(1, rdy1, val1, dat1, lst1, bsy1);
        end
        obs_val = val0;
        obs_dat = dat0;
        obs_lst = lst0;
        step_model(0);
        step_model(1);
        if (rst) model_ok = 1'b1;
    endtask

    initial begin
        logic [7:0] bits;
        int         nval, nlast;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; ser_ready = 1'b0;

        // Reset
        cycle(1, 0, 8'h00, 0);
        cycle(1, 0, 8'h00, 0);
        cycle(0, 0, 8'h00, 1);

        // Single word A5
        cycle(0, 1, 8'hA5, 1);
        bits = '0; nlast = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(0, 0, 8'h00, 1);
            bits = {bits[6:0], obs_dat};
            if (obs_lst) nlast++;
        end
        check("a5_bits", 32'(bits), 32'hA5);
        check("a5_last_count", 32'(nlast), 32'd1);
        cycle(0, 0, 8'h00, 1);
        check("a5_idle", 32'(obs_val), 32'd0);

        // Backpressure on C3: stall 3 cycles after bit 2
        cycle(0, 1, 8'hC3, 1);
        nval = 0; bits = '0;
        for (int k = 0; k < 11; k++) begin
            cycle(0, 0, 8'h00, !(k >= 2 && k < 5));
            if (obs_val) nval++;
            if (obs_val && !(k >= 2 && k < 5)) bits = {bits[6:0], obs_dat};
        end
        check("c3_cycles", 32'(nval), 32'd11);
        check("c3_bits", 32'(bits), 32'hC3);

        // Back-to-back FF then 00
        cycle(0, 1, 8'hFF, 1);
        nval = 0; nlast = 0;
        for (int k = 0; k < 16; k++) begin
            cycle(0, (k == 7), 8'h00, 1);
            if (obs_val) nval++;
            if (obs_lst) nlast++;
        end
        check("b2b_valid", 32'(nval), 32'd16);
        check("b2b_last", 32'(nlast), 32'd2);

        // F0 with an ignored 0F offered mid-word, then F0 again reset at bit 5
        cycle(0, 1, 8'hF0, 1);
        for (int k = 0; k < 8; k++) cycle(0, (k == 2), 8'h0F, 1);
        cycle(0, 1, 8'hF0, 1);
        nlast = 0;
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 8'h00, 1);
            if (obs_lst) nlast++;
        end
        cycle(1, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 1);
        if (obs_lst) nlast++;
        check("rst_mid_valid", 32'(obs_val), 32'd0);
        check("rst_mid_last", 32'(nlast), 32'd0);
        cycle(0, 1, 8'h3C, 1);
        for (int k = 0; k < 9; k++) cycle(0, 0, 8'h00, 1);

        // Word of zeros then hold: the fill-1 instance shows its fill at the chain top
        cycle(0, 1, 8'h00, 1);
        for (int k = 0; k < 10; k++) cycle(0, 0, 8'h00, 1);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(63) == 0), ($urandom_range(1) == 1), 8'($urandom),
                  ($urandom_range(3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
